flash_adc_sampler: RTL

Registered, parametrised flash-ADC back end that captures an N-bit comparator thermometer word, applies bubble correction, encodes it to binary and averages 2^AVG_LOG2 consecutive samples before presenting the result on a valid/ready output port. It sits between the comparator bank and the downstream sample consumer. It is the pipelined successor to the combinational thermometer decoder, generalised in resolution and adding oversampling and back-pressure handling.

---
 rtl/flash_adc_sampler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/flash_adc_sampler.sv
// Flash-ADC back end: captures a comparator thermometer word, corrects single bubbles,
// encodes to binary and averages 2^AVG_LOG2 samples onto a valid/ready output.
module flash_adc_sampler #(
  parameter int N_BITS   = 3,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [(2**N_BITS)-2:0]   COMP,
  input  logic                     clr_ovr,
  output logic [N_BITS-1:0]        raw_code,
  output logic                     bubble_err,
  output logic [N_BITS-1:0]        B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun
);

  localparam int NCOMP = (2**N_BITS) - 1;
  localparam int ACC_W = N_BITS + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2**AVG_LOG2) - 1);

  logic [NCOMP-1:0]  cap_q, cap_d;
  logic              cap_vld_q, cap_vld_d;
  logic [N_BITS-1:0] raw_q, raw_d;
  logic              berr_q, berr_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] b_q, b_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;

  // Captured word framed by the implied boundary bits: a 1 below bit 0, a 0 above the top.
  logic [NCOMP+1:0]  ext;
  logic [NCOMP-1:0]  corr;
  logic [N_BITS-1:0] code;
  logic [ACC_W-1:0]  sum;
  logic [N_BITS-1:0] result;
  logic              is_final;
  logic              new_res;
  logic              drop;

  assign ext = {1'b0, cap_q, 1'b1};

  generate
    for (genvar gi = 0; gi < NCOMP; gi++) begin : g_majority
      assign corr[gi] = (ext[gi] & ext[gi+1]) | (ext[gi] & ext[gi+2]) | (ext[gi+1] & ext[gi+2]);
    end
  endgenerate

  always_comb begin
    code = '0;
    for (int i = 0; i < NCOMP; i++) begin
      code = code + N_BITS'(corr[i]);
    end
  end

  // Worst-case sum is 2^AVG_LOG2 * (2^N_BITS - 1), which always fits in ACC_W bits.
  assign sum      = acc_q + ACC_W'(code);
  assign result   = N_BITS'(sum >> AVG_LOG2);
  assign is_final = (cnt_q == CNT_LAST);

  always_comb begin
    cap_d     = cap_q;
    cap_vld_d = sample_en;
    raw_d     = raw_q;
    berr_d    = 1'b0;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    vld_d     = vld_q;
    new_res   = 1'b0;
    drop      = 1'b0;

    if (sample_en) begin
      cap_d = COMP;
    end

    if (cap_vld_q) begin
      raw_d  = code;
      berr_d = (corr != cap_q);
      if (is_final) begin
        new_res = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A waiting result that is being consumed this edge may be replaced directly.
    if (new_res) begin
      if (!vld_q || out_ready) begin
        b_d   = result;
        vld_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q     <= '0;
      cap_vld_q <= 1'b0;
      raw_q     <= '0;
      berr_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      b_q       <= '0;
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      cap_vld_q <= cap_vld_d;
      raw_q     <= raw_d;
      berr_q    <= berr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      b_q       <= b_d;
      vld_q     <= vld_d;
      ovr_q     <= ovr_d;
    end
  end

  assign raw_code   = raw_q;
  assign bubble_err = berr_q;
  assign B          = b_q;
  assign out_valid  = vld_q;
  assign overrun    = ovr_q;

endmodule
